// File: rtl/rename_unit.sv
// Register rename stage: speculative and committed RATs plus a circular free list.
// Commit recycles stale tags; flush restores the committed mapping in one cycle.
module rename_unit #(
  parameter int unsigned ARCH_REGS = 32,
  parameter int unsigned PHY_REGS  = 64,
  parameter int unsigned FL_DEPTH  = PHY_REGS - ARCH_REGS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid,
  input  logic                          rd_en,
  input  logic [$clog2(ARCH_REGS)-1:0]  rs1_arch,
  input  logic [$clog2(ARCH_REGS)-1:0]  rs2_arch,
  input  logic [$clog2(ARCH_REGS)-1:0]  rd_arch,
  output logic                          rename_ready,
  output logic [$clog2(PHY_REGS)-1:0]   rs1_phy,
  output logic [$clog2(PHY_REGS)-1:0]   rs2_phy,
  output logic [$clog2(PHY_REGS)-1:0]   rd_phy,
  output logic [$clog2(PHY_REGS)-1:0]   rd_origin,
  input  logic                          commit_valid,
  input  logic                          commit_rd_en,
  input  logic [$clog2(ARCH_REGS)-1:0]  commit_rd_arch,
  input  logic [$clog2(PHY_REGS)-1:0]   commit_rd_phy,
  input  logic [$clog2(PHY_REGS)-1:0]   commit_rd_origin,
  input  logic                          flush
);

  localparam int unsigned TW = $clog2(PHY_REGS);
  localparam int unsigned IW = $clog2(FL_DEPTH);
  localparam int unsigned PW = IW + 1;

  logic [TW-1:0] spec_rat_q [ARCH_REGS];
  logic [TW-1:0] spec_rat_d [ARCH_REGS];
  logic [TW-1:0] arch_rat_q [ARCH_REGS];
  logic [TW-1:0] arch_rat_d [ARCH_REGS];
  logic [TW-1:0] fl_q [FL_DEPTH];
  logic [TW-1:0] fl_d [FL_DEPTH];
  logic [PW-1:0] spec_head_q, spec_head_d;
  logic [PW-1:0] arch_head_q, arch_head_d;
  logic [PW-1:0] tail_q, tail_d;

  logic [PW-1:0] count_c;
  logic          full_c;
  logic          alloc_c;
  logic          commit_c;

  // Pointer difference with a wrap bit gives occupancy in 0..FL_DEPTH.
  assign count_c      = tail_q - spec_head_q;
  assign full_c       = (count_c == PW'(FL_DEPTH));
  assign rename_ready = (count_c != '0);

  assign rs1_phy   = (rs1_arch == '0) ? '0 : spec_rat_q[rs1_arch];
  assign rs2_phy   = (rs2_arch == '0) ? '0 : spec_rat_q[rs2_arch];
  assign rd_origin = (rd_arch  == '0) ? '0 : spec_rat_q[rd_arch];
  assign rd_phy    = (rd_en && (rd_arch != '0)) ? fl_q[spec_head_q[IW-1:0]] : '0;

  assign alloc_c  = valid && rd_en && (rd_arch != '0) && !flush && rename_ready;
  assign commit_c = commit_valid && commit_rd_en && (commit_rd_arch != '0);

  // Commit is applied first so a same-cycle flush sees the retired mapping and head.
  always_comb begin
    spec_rat_d  = spec_rat_q;
    arch_rat_d  = arch_rat_q;
    fl_d        = fl_q;
    spec_head_d = spec_head_q;
    arch_head_d = arch_head_q;
    tail_d      = tail_q;
    if (commit_c) begin
      arch_rat_d[commit_rd_arch] = commit_rd_phy;
      fl_d[tail_q[IW-1:0]]       = commit_rd_origin;
      tail_d                     = tail_q + PW'(1);
      arch_head_d                = arch_head_q + PW'(1);
    end
    if (flush) begin
      spec_rat_d  = arch_rat_d;
      spec_head_d = arch_head_d;
    end else if (alloc_c) begin
      spec_rat_d[rd_arch] = rd_phy;
      spec_head_d         = spec_head_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < ARCH_REGS; i++) begin
        spec_rat_q[i] <= TW'(i);
        arch_rat_q[i] <= TW'(i);
      end
      for (int unsigned i = 0; i < FL_DEPTH; i++) begin
        fl_q[i] <= TW'(ARCH_REGS + i);
      end
      spec_head_q <= '0;
      arch_head_q <= '0;
      tail_q      <= PW'(FL_DEPTH);
    end else begin
      spec_rat_q  <= spec_rat_d;
      arch_rat_q  <= arch_rat_d;
      fl_q        <= fl_d;
      spec_head_q <= spec_head_d;
      arch_head_q <= arch_head_d;
      tail_q      <= tail_d;
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
    !(commit_c && full_c));
  a_no_alloc_when_empty: assert property (@(posedge clk) disable iff (!rst)
    !(valid && rd_en && (rd_arch != '0) && !rename_ready));

endmodule

// File: tb/tb_rename_unit.sv
// Self-checking bench for rename_unit: directed scenarios plus a randomized run
// against a free-list log / RAT array reference model.
module tb_rename_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid, rd_en, commit_valid, commit_rd_en, flush;
  logic [4:0] rs1_arch, rs2_arch, rd_arch, commit_rd_arch;
  logic [5:0] commit_rd_phy, commit_rd_origin;
  logic       rename_ready;
  logic [5:0] rs1_phy, rs2_phy, rd_phy, rd_origin;

  int checks = 0;
  int failures = 0;

  rename_unit dut (
    .clk(clk), .rst(rst), .valid(valid), .rd_en(rd_en),
    .rs1_arch(rs1_arch), .rs2_arch(rs2_arch), .rd_arch(rd_arch),
    .rename_ready(rename_ready), .rs1_phy(rs1_phy), .rs2_phy(rs2_phy),
    .rd_phy(rd_phy), .rd_origin(rd_origin),
    .commit_valid(commit_valid), .commit_rd_en(commit_rd_en),
    .commit_rd_arch(commit_rd_arch), .commit_rd_phy(commit_rd_phy),
    .commit_rd_origin(commit_rd_origin), .flush(flush)
  );

  initial forever #5 clk = ~clk;

  // Reference model: every tag ever placed on the free list, in order, with
  // plain integer indices for the speculative and committed heads.
  int spec_m [32];
  int arch_m [32];
  int log_q [$];
  int sh, ah;

  typedef struct { int arch; int tag; int origin; } rob_t;
  rob_t rob [$];

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      spec_m[i] = i;
      arch_m[i] = i;
    end
    log_q.delete();
    for (int i = 0; i < 32; i++) log_q.push_back(32 + i);
    sh = 0;
    ah = 0;
  endfunction

  function automatic int m_count();
    return log_q.size() - sh;
  endfunction

  function automatic void model_step();
    bit alloc, commit;
    alloc  = valid && rd_en && (rd_arch != 0) && !flush && (m_count() > 0);
    commit = commit_valid && commit_rd_en && (commit_rd_arch != 0);
    if (commit) begin
      arch_m[commit_rd_arch] = int'(commit_rd_phy);
      log_q.push_back(int'(commit_rd_origin));
      ah++;
    end
    if (flush) begin
      spec_m = arch_m;
      sh = ah;
    end else if (alloc) begin
      spec_m[rd_arch] = log_q[sh];
      sh++;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    valid = 0; rd_en = 0; rs1_arch = 0; rs2_arch = 0; rd_arch = 0;
    commit_valid = 0; commit_rd_en = 0; commit_rd_arch = 0;
    commit_rd_phy = 0; commit_rd_origin = 0; flush = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    rd_en = 1; rd_arch = 5'd1; rs1_arch = 5'd17; rs2_arch = 5'd31;
    #1;
    checks++; if (rename_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0d exp=1", rename_ready); end
    checks++; if (rs1_phy !== 6'd17) begin failures++; $display("FAIL reset_rs1 got=%0d exp=17", rs1_phy); end
    checks++; if (rs2_phy !== 6'd31) begin failures++; $display("FAIL reset_rs2 got=%0d exp=31", rs2_phy); end
    checks++; if (rd_phy !== 6'd32) begin failures++; $display("FAIL reset_rd_phy got=%0d exp=32", rd_phy); end
    idle();
  endtask

  task automatic test_first_rename();
    do_reset();
    valid = 1; rd_en = 1; rd_arch = 5'd5; rs1_arch = 5'd5;
    #1;
    checks++; if (rd_phy !== 6'd32) begin failures++; $display("FAIL first_rd_phy got=%0d exp=32", rd_phy); end
    checks++; if (rd_origin !== 6'd5) begin failures++; $display("FAIL first_rd_origin got=%0d exp=5", rd_origin); end
    checks++; if (rs1_phy !== 6'd5) begin failures++; $display("FAIL first_rs1_old got=%0d exp=5", rs1_phy); end
    tick();
    valid = 0; rd_arch = 5'd3;
    #1;
    checks++; if (rs1_phy !== 6'd32) begin failures++; $display("FAIL first_rs1_new got=%0d exp=32", rs1_phy); end
    checks++; if (rd_phy !== 6'd33) begin failures++; $display("FAIL first_next_head got=%0d exp=33", rd_phy); end
    idle();
  endtask

  task automatic test_r0_dest();
    valid = 1; rd_en = 1; rd_arch = 5'd0;
    #1;
    checks++; if (rd_phy !== 6'd0) begin failures++; $display("FAIL r0_rd_phy got=%0d exp=0", rd_phy); end
    checks++; if (rd_origin !== 6'd0) begin failures++; $display("FAIL r0_rd_origin got=%0d exp=0", rd_origin); end
    tick();
    valid = 0; rs1_arch = 5'd0; rd_arch = 5'd3;
    #1;
    checks++; if (rs1_phy !== 6'd0) begin failures++; $display("FAIL r0_rat got=%0d exp=0", rs1_phy); end
    checks++; if (rd_phy !== 6'd33) begin failures++; $display("FAIL r0_no_alloc got=%0d exp=33", rd_phy); end
    idle();
  endtask

  task automatic test_exhaustion();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      valid = 1; rd_en = 1; rd_arch = (i < 31) ? 5'(i + 1) : 5'd1;
      #1;
      checks++; if (rd_phy !== 6'(32 + i)) begin failures++; $display("FAIL exhaust_rd_phy[%0d] got=%0d exp=%0d", i, rd_phy, 32 + i); end
      tick();
    end
    idle();
    #1;
    checks++; if (rename_ready !== 1'b0) begin failures++; $display("FAIL exhaust_empty got=%0d exp=0", rename_ready); end
    commit_valid = 1; commit_rd_en = 1; commit_rd_arch = 5'd1;
    commit_rd_phy = 6'd32; commit_rd_origin = 6'd1;
    tick();
    idle();
    rd_en = 1; rd_arch = 5'd2;
    #1;
    checks++; if (rename_ready !== 1'b1) begin failures++; $display("FAIL exhaust_refill_ready got=%0d exp=1", rename_ready); end
    checks++; if (rd_phy !== 6'd1) begin failures++; $display("FAIL exhaust_wrap_tag got=%0d exp=1", rd_phy); end
    checks++; if (rd_origin !== 6'd33) begin failures++; $display("FAIL exhaust_origin got=%0d exp=33", rd_origin); end
    idle();
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 22; i++) begin
      valid = 1; rd_en = 1; rd_arch = 5'(i + 1);
      tick();
    end
    rd_arch = 5'd7;
    commit_valid = 1; commit_rd_en = 1; commit_rd_arch = 5'd3;
    commit_rd_phy = 6'd34; commit_rd_origin = 6'd3;
    #1;
    checks++; if (rd_phy !== 6'd54) begin failures++; $display("FAIL simul_rd_phy got=%0d exp=54", rd_phy); end
    checks++; if (rd_origin !== 6'd38) begin failures++; $display("FAIL simul_origin got=%0d exp=38", rd_origin); end
    tick();
    idle();
    for (int k = 0; k < 10; k++) begin
      valid = 1; rd_en = 1; rd_arch = 5'd10;
      #1;
      checks++; if (rd_phy !== ((k < 9) ? 6'(55 + k) : 6'd3)) begin failures++; $display("FAIL simul_drain[%0d] got=%0d exp=%0d", k, rd_phy, (k < 9) ? 55 + k : 3); end
      tick();
    end
    idle();
    #1;
    checks++; if (rename_ready !== 1'b0) begin failures++; $display("FAIL simul_count got=%0d exp=0", rename_ready); end
  endtask

  task automatic rename_4_6_commit_4();
    do_reset();
    valid = 1; rd_en = 1; rd_arch = 5'd4; tick();
    rd_arch = 5'd6; tick();
    idle();
    commit_valid = 1; commit_rd_en = 1; commit_rd_arch = 5'd4;
    commit_rd_phy = 6'd32; commit_rd_origin = 6'd4;
    tick();
    idle();
  endtask

  task automatic test_flush_recovery();
    rename_4_6_commit_4();
    flush = 1;
    tick();
    idle();
    rs1_arch = 5'd4; rs2_arch = 5'd6; rd_en = 1; rd_arch = 5'd1;
    #1;
    checks++; if (rs1_phy !== 6'd32) begin failures++; $display("FAIL flush_rat4 got=%0d exp=32", rs1_phy); end
    checks++; if (rs2_phy !== 6'd6) begin failures++; $display("FAIL flush_rat6 got=%0d exp=6", rs2_phy); end
    checks++; if (rd_phy !== 6'd33) begin failures++; $display("FAIL flush_head got=%0d exp=33", rd_phy); end
    checks++; if (rename_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%0d exp=1", rename_ready); end
    idle();
  endtask

  task automatic test_flush_commit_valid();
    rename_4_6_commit_4();
    flush = 1;
    commit_valid = 1; commit_rd_en = 1; commit_rd_arch = 5'd6;
    commit_rd_phy = 6'd33; commit_rd_origin = 6'd6;
    valid = 1; rd_en = 1; rd_arch = 5'd9;
    tick();
    idle();
    rs1_arch = 5'd6; rs2_arch = 5'd9; rd_en = 1; rd_arch = 5'd1;
    #1;
    checks++; if (rs1_phy !== 6'd33) begin failures++; $display("FAIL fcv_rat6 got=%0d exp=33", rs1_phy); end
    checks++; if (rs2_phy !== 6'd9) begin failures++; $display("FAIL fcv_rat9 got=%0d exp=9", rs2_phy); end
    checks++; if (rd_phy !== 6'd34) begin failures++; $display("FAIL fcv_head got=%0d exp=34", rd_phy); end
    idle();
  endtask

  task automatic test_random();
    bit   do_commit, will_alloc;
    rob_t ent;
    do_reset();
    rob.delete();
    for (int c = 0; c < 3000; c++) begin
      idle();
      do_commit = (rob.size() > 0) && ($urandom_range(0, 99) < 45);
      if (do_commit) begin
        commit_valid = 1; commit_rd_en = 1;
        commit_rd_arch = 5'(rob[0].arch);
        commit_rd_phy = 6'(rob[0].tag);
        commit_rd_origin = 6'(rob[0].origin);
      end else if ($urandom_range(0, 9) == 0) begin
        commit_valid = 1; commit_rd_en = 0;
        commit_rd_arch = 5'($urandom); commit_rd_phy = 6'($urandom); commit_rd_origin = 6'($urandom);
      end
      flush = ($urandom_range(0, 24) == 0);
      rs1_arch = 5'($urandom); rs2_arch = 5'($urandom);
      rd_arch = ($urandom_range(0, 15) == 0) ? 5'd0 : 5'($urandom);
      rd_en = ($urandom_range(0, 9) != 0);
      valid = ($urandom_range(0, 99) < 60);
      if (valid && rd_en && rd_arch != 0 && m_count() == 0) valid = 0;
      #1;
      checks++; if (rename_ready !== (m_count() > 0)) begin failures++; $display("FAIL rand_ready cyc=%0d got=%0d exp=%0d", c, rename_ready, m_count() > 0); end
      checks++; if (rs1_phy !== 6'(spec_m[rs1_arch])) begin failures++; $display("FAIL rand_rs1 cyc=%0d got=%0d exp=%0d", c, rs1_phy, spec_m[rs1_arch]); end
      checks++; if (rs2_phy !== 6'(spec_m[rs2_arch])) begin failures++; $display("FAIL rand_rs2 cyc=%0d got=%0d exp=%0d", c, rs2_phy, spec_m[rs2_arch]); end
      checks++; if (rd_origin !== 6'(spec_m[rd_arch])) begin failures++; $display("FAIL rand_origin cyc=%0d got=%0d exp=%0d", c, rd_origin, spec_m[rd_arch]); end
      if (!(rd_en && rd_arch != 0)) begin
        checks++; if (rd_phy !== 6'd0) begin failures++; $display("FAIL rand_rd_zero cyc=%0d got=%0d exp=0", c, rd_phy); end
      end else if (m_count() > 0) begin
        checks++; if (rd_phy !== 6'(log_q[sh])) begin failures++; $display("FAIL rand_rd_phy cyc=%0d got=%0d exp=%0d", c, rd_phy, log_q[sh]); end
      end
      will_alloc = valid && rd_en && (rd_arch != 0) && !flush && (m_count() > 0);
      if (will_alloc) ent = '{int'(rd_arch), log_q[sh], spec_m[rd_arch]};
      tick();
      if (do_commit) void'(rob.pop_front());
      if (flush) rob.delete();
      else if (will_alloc) rob.push_back(ent);
    end
    idle();
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2;
    rst = 0;
    rs1_arch = 5'(rob.size() > 0 ? rob[0].arch : 7);
    rd_en = 1; rd_arch = 5'd1;
    #1;
    checks++; if (rename_ready !== 1'b1) begin failures++; $display("FAIL async_ready got=%0d exp=1", rename_ready); end
    checks++; if (rs1_phy !== 6'(rs1_arch)) begin failures++; $display("FAIL async_rat got=%0d exp=%0d", rs1_phy, rs1_arch); end
    checks++; if (rd_phy !== 6'd32) begin failures++; $display("FAIL async_head got=%0d exp=32", rd_phy); end
    idle();
    model_reset();
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    idle();
    rst = 0;
    test_reset();
    test_first_rename();
    test_r0_dest();
    test_exhaustion();
    test_simultaneous();
    test_flush_recovery();
    test_flush_commit_valid();
    test_random();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
